// File: rtl/intc_responder_pkg.sv
// Shared types and constants for the interrupt responder: FSM states,
// configuration register map and the source-count ceiling.
package intc_pkg;

  localparam int MAX_SRC = 16;

  localparam logic [1:0] REG_MASK  = 2'd0;
  localparam logic [1:0] REG_EDGE  = 2'd1;
  localparam logic [1:0] REG_PEND  = 2'd2;
  localparam logic [1:0] REG_INSVC = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/intc_responder_if.sv
// CPU-side interrupt handshake: irq/iack request-acknowledge plus the vector
// return path and the end-of-interrupt strobe.
//
// Handshake: irq is a level request held by the controller; the CPU raises
// iack (one or more cycles) and the vector is valid on vec_data the cycle
// after iack is first sampled, for as long as vec_valid stays high.
interface intc_responder_if;
  logic        irq;
  logic        iack;
  logic        eoi;
  logic [15:0] vec_data;
  logic        vec_valid;

  modport master (
    input  irq,
    input  vec_data,
    input  vec_valid,
    output iack,
    output eoi
  );

  modport slave (
    output irq,
    output vec_data,
    output vec_valid,
    input  iack,
    input  eoi
  );
endinterface

// File: rtl/intc_responder_prio_enc.sv
// Find-lowest-set-bit encoder; index 0 is the highest priority.
module intc_prio_enc #(
  parameter int W = 8
) (
  input  logic [W-1:0] bits,
  output logic         found,
  output logic [3:0]   idx
);

  // Scan downward so the lowest set bit is the last to write idx.
  always_comb begin
    found = 1'b0;
    idx   = 4'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (bits[i]) begin
        found = 1'b1;
        idx   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/intc_responder.sv
// Interrupt controller at the device end of the CPU irq/iack handshake:
// synchronizes sources, keeps MASK/EDGE/PENDING/INSERVICE, returns vectors.
module intc_responder
  import intc_pkg::*;
#(
  parameter int         NUM_SRC  = 8,
  parameter logic [7:0] VEC_BASE = 8'h20,
  parameter logic [7:0] SPUR_VEC = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  intc_responder_if.slave     bus,
  input  logic [NUM_SRC-1:0]  src,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [15:0]         cfg_wdata,
  output logic [15:0]         cfg_rdata,
  output state_t              state_dbg
);

  state_t state, state_nxt;

  logic [NUM_SRC-1:0] sync1, sync2, sync3;
  logic [NUM_SRC-1:0] mask_q, edge_q, pend_q, insvc_q;
  logic [NUM_SRC-1:0] set_vec, cfg_clr, ack_set, eoi_clr;
  logic [NUM_SRC-1:0] eligible;
  logic [3:0]         win_idx, insvc_idx, win_q;
  logic               win_found, insvc_found, win_valid_q;
  logic               ack_first, latch_en, req_exists;
  logic [4:0]         ceiling;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign set_vec  = (edge_q & sync2 & ~sync3) | (~edge_q & sync2);
  assign eligible = pend_q & ~mask_q;

  intc_prio_enc #(.W(NUM_SRC)) u_win_enc (
    .bits  (eligible),
    .found (win_found),
    .idx   (win_idx)
  );

  intc_prio_enc #(.W(NUM_SRC)) u_ceil_enc (
    .bits  (insvc_q),
    .found (insvc_found),
    .idx   (insvc_idx)
  );

  assign ceiling    = insvc_found ? {1'b0, insvc_idx} : 5'(NUM_SRC);
  assign req_exists = win_found && ({1'b0, win_idx} < ceiling);

  always_comb begin
    cfg_clr = '0;
    ack_set = '0;
    eoi_clr = '0;
    if (cfg_we && cfg_addr == REG_PEND)
      cfg_clr = cfg_wdata[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_set[i] = ack_first && win_valid_q && (win_q == 4'(i));
      eoi_clr[i] = bus.eoi && insvc_found && (insvc_idx == 4'(i));
    end
  end

  // The acknowledge clear beats a same-cycle level set, so a level source
  // that is still high shows up pending again one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q  <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      insvc_q <= '0;
    end else begin
      if (cfg_we && cfg_addr == REG_MASK) mask_q <= cfg_wdata[NUM_SRC-1:0];
      if (cfg_we && cfg_addr == REG_EDGE) edge_q <= cfg_wdata[NUM_SRC-1:0];
      pend_q  <= ((pend_q & ~cfg_clr) | set_vec) & ~ack_set;
      insvc_q <= (insvc_q & ~eoi_clr) | ack_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      ack_first   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ack_first <= latch_en;
      if (latch_en) begin
        win_q       <= win_idx;
        win_valid_q <= req_exists;
      end
    end
  end

  // An iack that races a vanishing request still wins; the CPU gets the
  // spurious vector instead of a dangling acknowledge.
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    case (state)
      IDLE: if (req_exists) state_nxt = REQ;
      REQ: begin
        if (bus.iack) begin
          state_nxt = ACK;
          latch_en  = 1'b1;
        end else if (!req_exists) begin
          state_nxt = IDLE;
        end
      end
      ACK: if (!bus.iack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.irq       = (state == REQ);
    bus.vec_valid = (state == ACK);
    bus.vec_data  = 16'h0000;
    if (state == ACK)
      bus.vec_data = {8'h00, win_valid_q ? (VEC_BASE + 8'(win_q)) : SPUR_VEC};
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_MASK:  cfg_rdata[NUM_SRC-1:0] = mask_q;
      REG_EDGE:  cfg_rdata[NUM_SRC-1:0] = edge_q;
      REG_PEND:  cfg_rdata[NUM_SRC-1:0] = pend_q;
      default:   cfg_rdata[NUM_SRC-1:0] = insvc_q;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_intc_responder.sv
// Directed bench for intc_responder: edge/level capture, priority and
// nesting, mask-while-requesting, spurious vectors and reset during ACK.
module tb_intc_responder;
  import intc_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  state_t      state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wait;

  intc_responder_if bus();

  intc_responder #(
    .NUM_SRC  (8),
    .VEC_BASE (8'h20),
    .SPUR_VEC (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .src       (src),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
    cfg_addr = a;
    #1;
    check_eq(tag, cfg_rdata, exp);
  endtask

  task automatic wait_irq(input string tag, input int max, output int n);
    n = 0;
    while (bus.irq !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {15'd0, bus.irq}, 16'h0001);
  endtask

  task automatic ack_check(input string tag, input logic [15:0] exp_vec);
    bus.iack = 1'b1;
    @(negedge clk);
    check_eq({tag, "_valid"}, {15'd0, bus.vec_valid}, 16'h0001);
    check_eq({tag, "_vec"}, bus.vec_data, exp_vec);
    check_eq({tag, "_irq_low"}, {15'd0, bus.irq}, 16'h0000);
    bus.iack = 1'b0;
    @(negedge clk);
    check_eq({tag, "_valid_end"}, {15'd0, bus.vec_valid}, 16'h0000);
    check_eq({tag, "_vec_end"}, bus.vec_data, 16'h0000);
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1;
    @(negedge clk);
    bus.eoi = 1'b0;
  endtask

  task automatic drain_all();
    src = 8'h00;
    repeat (4) @(negedge clk);
    cfg_write(REG_PEND, 16'h00FF);
    cfg_write(REG_MASK, 16'h0000);
    pulse_eoi();
    pulse_eoi();
    @(negedge clk);
  endtask

  initial begin
    logic irq_seen;
    reset     = 1'b1;
    src       = 8'h00;
    cfg_we    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = 16'h0000;
    bus.iack  = 1'b0;
    bus.eoi   = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_irq", {15'd0, bus.irq}, 16'h0000);
    check_eq("rst_valid", {15'd0, bus.vec_valid}, 16'h0000);
    check_eq("rst_vec", bus.vec_data, 16'h0000);
    check_eq("rst_state", {14'd0, state_dbg}, {14'd0, IDLE});
    reset = 1'b0;
    @(negedge clk);
    check_reg("rst_pend", REG_PEND, 16'h0000);
    check_reg("rst_insvc", REG_INSVC, 16'h0000);

    // Edge source 3
    cfg_write(REG_EDGE, 16'h0008);
    check_reg("edge_rd", REG_EDGE, 16'h0008);
    src = 8'h08;
    wait_irq("t1_irq", 10, n_wait);
    check_eq("t1_latency", 16'(n_wait), 16'd4);
    ack_check("t1", 16'h0023);
    check_reg("t1_pend", REG_PEND, 16'h0000);
    check_reg("t1_insvc", REG_INSVC, 16'h0008);
    cfg_write(REG_INSVC, 16'h0000);
    check_reg("t1_insvc_ro", REG_INSVC, 16'h0008);
    src = 8'h00;
    pulse_eoi();
    check_reg("t1_eoi", REG_INSVC, 16'h0000);

    // Level sources 5 and 2 together
    cfg_write(REG_EDGE, 16'h0000);
    src = 8'h24;
    wait_irq("t2_irq", 10, n_wait);
    ack_check("t2a", 16'h0022);
    check_reg("t2_insvc", REG_INSVC, 16'h0004);
    irq_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      irq_seen |= bus.irq;
    end
    check_eq("t2_blocked", {15'd0, irq_seen}, 16'h0000);
    src = 8'h20;
    repeat (4) @(negedge clk);
    cfg_write(REG_PEND, 16'h0004);
    pulse_eoi();
    wait_irq("t2_irq2", 10, n_wait);
    ack_check("t2b", 16'h0025);
    check_reg("t2_insvc2", REG_INSVC, 16'h0020);
    drain_all();

    // Nesting: 4 in service, 1 preempts
    src = 8'h10;
    wait_irq("t3_irq", 10, n_wait);
    ack_check("t3a", 16'h0024);
    src = 8'h12;
    wait_irq("t3_irq2", 10, n_wait);
    ack_check("t3b", 16'h0021);
    check_reg("t3_insvc", REG_INSVC, 16'h0012);
    src = 8'h00;
    repeat (4) @(negedge clk);
    cfg_write(REG_PEND, 16'h00FF);
    pulse_eoi();
    check_reg("t3_eoi", REG_INSVC, 16'h0010);
    drain_all();
    check_reg("t3_clean", REG_INSVC, 16'h0000);

    // Mask written while in REQ
    src = 8'h40;
    wait_irq("t4_irq", 10, n_wait);
    check_eq("t4_state_req", {14'd0, state_dbg}, {14'd0, REQ});
    cfg_write(REG_MASK, 16'h0040);
    @(negedge clk);
    check_eq("t4_irq_drop", {15'd0, bus.irq}, 16'h0000);
    check_eq("t4_state_idle", {14'd0, state_dbg}, {14'd0, IDLE});
    bus.iack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("t4_no_vec", {15'd0, bus.vec_valid}, 16'h0000);
    end
    bus.iack = 1'b0;
    drain_all();

    // Late iack after source 0 is masked: spurious vector
    src = 8'h01;
    wait_irq("t5_irq", 10, n_wait);
    cfg_addr  = REG_MASK;
    cfg_wdata = 16'h0001;
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
    src       = 8'h00;
    bus.iack  = 1'b1;
    @(negedge clk);
    check_eq("t5_valid", {15'd0, bus.vec_valid}, 16'h0001);
    check_eq("t5_vec", bus.vec_data, 16'h00FF);
    bus.iack = 1'b0;
    @(negedge clk);
    check_reg("t5_insvc", REG_INSVC, 16'h0000);
    drain_all();

    // Reset during ACK with iack held
    src = 8'h08;
    wait_irq("t6_irq", 10, n_wait);
    bus.iack = 1'b1;
    @(negedge clk);
    check_eq("t6_valid", {15'd0, bus.vec_valid}, 16'h0001);
    @(negedge clk);
    check_reg("t6_insvc_pre", REG_INSVC, 16'h0008);
    reset = 1'b1;
    #1;
    check_eq("t6_irq", {15'd0, bus.irq}, 16'h0000);
    check_eq("t6_valid_rst", {15'd0, bus.vec_valid}, 16'h0000);
    check_eq("t6_vec_rst", bus.vec_data, 16'h0000);
    check_reg("t6_pend_rst", REG_PEND, 16'h0000);
    check_reg("t6_insvc_rst", REG_INSVC, 16'h0000);
    @(negedge clk);
    bus.iack = 1'b0;
    reset    = 1'b0;
    wait_irq("t6_irq2", 10, n_wait);
    ack_check("t6b", 16'h0023);
    drain_all();

    // eoi in the ACK entry cycle clears the older in-service bit only
    src = 8'h10;
    wait_irq("t7_irq", 10, n_wait);
    ack_check("t7a", 16'h0024);
    src = 8'h12;
    wait_irq("t7_irq2", 10, n_wait);
    bus.iack = 1'b1;
    @(negedge clk);
    check_eq("t7_vec", bus.vec_data, 16'h0021);
    bus.eoi  = 1'b1;
    bus.iack = 1'b0;
    @(negedge clk);
    bus.eoi = 1'b0;
    check_reg("t7_insvc", REG_INSVC, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/intc_responder.md
Name: intc_responder

Overview:
- Interrupt controller sitting at the device end of the CPU's irq/iack handshake.
- Collects NUM_SRC peripheral interrupt lines, applies mask and edge/level configuration, and resolves fixed priority (lowest index wins).
- Drives irq to the microcoded control FSM. When the FSM acknowledges with iack, the block returns an 8-bit vector on the data bus and tracks the in-service source until the CPU signals end-of-interrupt.

Parameters:
- NUM_SRC, 8: number of interrupt sources, legal range 1..16.
- VEC_BASE, 8'h20: vector for source 0. Source i yields VEC_BASE+i.
- SPUR_VEC, 8'hFF: vector returned when an acknowledge finds no eligible source.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- src  in  NUM_SRC  raw peripheral interrupt lines, asynchronous to clk
- irq  out  1  interrupt request to the CPU control FSM
- iack  in  1  acknowledge from the CPU, held high one or more cycles
- eoi  in  1  single-cycle end-of-interrupt strobe from the CPU
- vec_data  out  16  {8'h00, vector}, valid while vec_valid=1
- vec_valid  out  1  vector on vec_data is valid
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  2  0=MASK, 1=EDGE, 2=PENDING (write 1 to clear), 3=INSERVICE (read only)
- cfg_wdata  in  16  write data; bits above NUM_SRC-1 ignored
- cfg_rdata  out  16  combinational readback of the addressed register, zero-extended

Behaviour:
- Reset (asynchronous) clears the synchronizers, MASK, EDGE, PENDING, INSERVICE, the latched winner and the FSM (state IDLE). While reset is high: irq=0, vec_valid=0, vec_data=0.
- Synchronization: each src bit passes through a 2-flop synchronizer. Rising-edge detection uses a third flop.
- PENDING[i] set rule:
  - EDGE[i]=1: set on a synchronized rising edge.
  - EDGE[i]=0: set every cycle the synchronized level is 1.
  - A set has priority over a cfg clear in the same cycle.
- Eligible set: PENDING & ~MASK.
  - Winner = lowest eligible index.
  - Priority ceiling = lowest INSERVICE index, or NUM_SRC if none.
  - A request exists when the winner index is below the ceiling (nested preemption only by higher priority).
- FSM states:
  - IDLE: irq=0. Go to REQ when a request exists.
  - REQ: irq=1. If the request disappears before iack (masked or cleared), go back to IDLE and drop irq the next cycle. On iack=1, latch the winner (or spurious if none) and go to ACK.
  - ACK (entered one cycle after iack is first sampled high): irq=0, vec_valid=1, vec_data={8'h00, VEC_BASE+winner} or {8'h00, SPUR_VEC}. For a real winner, set INSERVICE[winner] and clear PENDING[winner] in the ACK entry cycle. Level sources re-pend next cycle if the line is still high. Stay in ACK while iack=1.
  - ACK exit: when iack=0, go to IDLE; vec_valid=0 and vec_data=0 that cycle.
- Latency: iack sampled high in cycle N, vector valid in cycle N+1. A single-cycle iack therefore gives exactly one cycle of vec_valid. A new irq cannot assert earlier than 1 cycle after ACK exit.
- eoi clears the lowest-index set INSERVICE bit. eoi with INSERVICE=0 is ignored.
- eoi in the same cycle as the ACK entry: the clear applies to the pre-update INSERVICE, then the set applies. The new bit is never cleared by that eoi.
- iack while in IDLE is ignored, with no vector.
- cfg writes take effect the next cycle. Writes to INSERVICE are ignored.

Decomposition:
- Package intc_pkg:
  - FSM state enum (IDLE, REQ, ACK).
  - Register address constants (REG_MASK, REG_EDGE, REG_PEND, REG_INSVC).
  - Maximum source count of 16.
- Sub-module intc_prio_enc: parameterized find-lowest-set-bit returning {found, index[3:0]}. Instantiated twice, once for the winner and once for the INSERVICE ceiling.

Test Plan:
- Edge source 3 pulses (EDGE=8'h08, MASK=0); iack held 1 cycle -> irq rises 3–4 cycles after the pulse; vec_data=16'h0023 with vec_valid for exactly 1 cycle; INSERVICE=8'h08; PENDING=0.
- Level sources 5 and 2 high together; ack -> vector 8'h22; no new irq until eoi because source 5 sits below the ceiling; after eoi, irq rises and the next ack returns 8'h25.
- Nesting: source 4 in service; source 1 asserts -> irq rises; ack returns 8'h21; INSERVICE=8'h12; eoi clears bit 1 only (INSERVICE=8'h10).
- Source 6 pending, then MASK=8'h40 written while in REQ -> irq drops, state returns to IDLE; a subsequent iack yields no vec_valid.
- Source 0 drops before a late iack (level mode, masked in the same cycle as the iack sample) -> vec_data=16'h00FF and INSERVICE unchanged.
- Reset asserted during ACK with iack high -> irq, vec_valid, PENDING and INSERVICE all 0 immediately; normal operation after release.
